// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the iCE40 PLL in reset, qualifies lock, then releases the system reset.
// Optional FAULT_LATCH_EN adds a sticky fault after MAX_RETRIES consecutive lock timeouts.
module pll_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RESET_CYCLES   = 64,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_resetb,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [3:0] relock_count,
    output logic       fault
);

    localparam int HOLD_W    = $clog2(HOLD_CYCLES);
    localparam int RESET_W   = $clog2(RESET_CYCLES);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES);
    localparam int STABLE_W  = $clog2(STABLE_CYCLES);
    localparam int CW_HR     = (HOLD_W > RESET_W) ? HOLD_W : RESET_W;
    localparam int CW        = (CW_HR > TIMEOUT_W) ? CW_HR : TIMEOUT_W;

    localparam logic [CW-1:0]       HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]       RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]       TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(STABLE_CYCLES - 1);

`ifdef FAULT_LATCH_EN
    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam int                 RETRY_W    = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               r_fault;
`else
    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN
    } state_t;

    logic w_unused_retries;
    assign w_unused_retries = (MAX_RETRIES > 0);
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [STABLE_W-1:0] r_stable;
    logic [STABLE_W-1:0] w_stable_nxt;
    logic [3:0]          r_relock;
    logic [3:0]          w_relock_nxt;
    logic                r_sync1;
    logic                r_lock_s;
    logic                r_pll_resetb;
    logic                r_sys_rst_n;
    logic                r_ready;

    // A single duration counter serves the hold, timeout and settle phases; it restarts on every state change.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_stable_nxt = '0;
        w_relock_nxt = r_relock;
`ifdef FAULT_LATCH_EN
        w_retry_nxt  = r_retry;
`endif
        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                w_stable_nxt = r_lock_s ? (r_stable + 1'b1) : '0;
                if (r_lock_s && (r_stable == STABLE_LAST)) begin
                    w_state_nxt = ST_SETTLE;
`ifdef FAULT_LATCH_EN
                    w_retry_nxt = '0;
`endif
                end else if (r_cnt == TIMEOUT_LAST) begin
`ifdef FAULT_LATCH_EN
                    if (r_retry == RETRY_LAST) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_PLL_RST;
                    end
                    w_retry_nxt = r_retry + 1'b1;
`else
                    w_state_nxt = ST_PLL_RST;
`endif
                end
            end
            ST_SETTLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_PLL_RST;
                    if (r_relock != 4'd15) begin
                        w_relock_nxt = r_relock + 4'd1;
                    end
                end else if (r_cnt == RESET_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt;
                if (!r_lock_s) begin
                    w_state_nxt = ST_PLL_RST;
                    if (r_relock != 4'd15) begin
                        w_relock_nxt = r_relock + 4'd1;
                    end
                end
            end
`ifdef FAULT_LATCH_EN
            ST_FAULT: begin
                w_cnt_nxt = r_cnt;
            end
`endif
            default: begin
                w_state_nxt = ST_PLL_RST;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt    = '0;
            w_stable_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PLL_RST;
            r_cnt        <= '0;
            r_stable     <= '0;
            r_relock     <= '0;
            r_sync1      <= 1'b0;
            r_lock_s     <= 1'b0;
            r_pll_resetb <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_ready      <= 1'b0;
`ifdef FAULT_LATCH_EN
            r_retry      <= '0;
            r_fault      <= 1'b0;
`endif
        end else begin
            r_sync1      <= pll_locked;
            r_lock_s     <= r_sync1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stable     <= w_stable_nxt;
            r_relock     <= w_relock_nxt;
            r_sys_rst_n  <= (w_state_nxt == ST_RUN);
            r_ready      <= (w_state_nxt == ST_RUN);
`ifdef FAULT_LATCH_EN
            r_retry      <= w_retry_nxt;
            r_fault      <= (w_state_nxt == ST_FAULT);
            r_pll_resetb <= (w_state_nxt != ST_PLL_RST) && (w_state_nxt != ST_FAULT);
`else
            r_pll_resetb <= (w_state_nxt != ST_PLL_RST);
`endif
        end
    end

    assign pll_resetb   = r_pll_resetb;
    assign sys_rst_n    = r_sys_rst_n;
    assign ready        = r_ready;
    assign relock_count = r_relock;
`ifdef FAULT_LATCH_EN
    assign fault        = r_fault;
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer with shortened timing parameters.
// Expected output words are queued per edge number (edges counted after rst_n rises).
module tb_pll_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_resetb;
    logic       sys_rst_n;
    logic       ready;
    logic [3:0] relock_count;
    logic       fault;
    logic [7:0] observed;

    exp_t sbq[$];
    exp_t e;
    int   cyc;
    int   vectors = 0;
    int   miscompares = 0;

    pll_reset_sequencer #(
        .HOLD_CYCLES   (4),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(32),
        .RESET_CYCLES  (4),
        .MAX_RETRIES   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .pll_resetb  (pll_resetb),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .relock_count(relock_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    assign observed = {fault, relock_count, ready, sys_rst_n, pll_resetb};

    function automatic logic [7:0] ev(input logic f, input logic [3:0] rc, input logic rdy,
                                      input logic s, input logic rb);
        return {f, rc, rdy, s, rb};
    endfunction

    task automatic expectAt(input int c, input logic [7:0] v, input string n);
        exp_t x;
        x.cyc  = c;
        x.val  = v;
        x.name = n;
        sbq.push_back(x);
    endtask

    task automatic doReset(input logic lockVal);
        rst_n      = 1'b0;
        pll_locked = lockVal;
        sbq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        #2;
        vectors++;
        if (observed !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_async got=%b want=%b", observed, 8'h00);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (observed !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_held got=%b want=%b", observed, 8'h00);
        end
    endtask

    task automatic test_locked_startup();
        doReset(1'b1);
        expectAt(3,  ev(0, 0, 0, 0, 0), "startup_hold_e3");
        expectAt(4,  ev(0, 0, 0, 0, 1), "startup_resetb_e4");
        expectAt(15, ev(0, 0, 0, 0, 1), "startup_sys_e15");
        expectAt(16, ev(0, 0, 1, 1, 1), "startup_run_e16");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (observed !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, observed, e.val);
                end
            end
        end
    endtask

    task automatic test_lock_glitch();
        doReset(1'b1);
        expectAt(16, ev(0, 0, 0, 0, 1), "glitch_no_run_e16");
        expectAt(21, ev(0, 0, 0, 0, 1), "glitch_sys_e21");
        expectAt(22, ev(0, 0, 1, 1, 1), "glitch_run_e22");
        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (observed !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, observed, e.val);
                end
            end
            if (cyc == 7) pll_locked = 1'b0;
            if (cyc == 8) pll_locked = 1'b1;
        end
    endtask

    task automatic test_no_lock();
        doReset(1'b0);
        expectAt(3,  ev(0, 0, 0, 0, 0), "nolock_hold_e3");
        expectAt(4,  ev(0, 0, 0, 0, 1), "nolock_wait_e4");
        expectAt(35, ev(0, 0, 0, 0, 1), "nolock_wait_e35");
        expectAt(36, ev(0, 0, 0, 0, 0), "nolock_timeout1_e36");
        expectAt(39, ev(0, 0, 0, 0, 0), "nolock_hold_e39");
        expectAt(40, ev(0, 0, 0, 0, 1), "nolock_wait_e40");
        expectAt(71, ev(0, 0, 0, 0, 1), "nolock_wait_e71");
`ifdef FAULT_LATCH_EN
        expectAt(72,  ev(1, 0, 0, 0, 0), "fault_set_e72");
        expectAt(108, ev(1, 0, 0, 0, 0), "fault_held_e108");
`else
        expectAt(72,  ev(0, 0, 0, 0, 0), "nolock_timeout2_e72");
        expectAt(75,  ev(0, 0, 0, 0, 0), "nolock_hold_e75");
        expectAt(76,  ev(0, 0, 0, 0, 1), "nolock_wait_e76");
        expectAt(107, ev(0, 0, 0, 0, 1), "nolock_wait_e107");
        expectAt(108, ev(0, 0, 0, 0, 0), "nolock_timeout3_e108");
`endif
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (observed !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, observed, e.val);
                end
            end
        end
`ifdef FAULT_LATCH_EN
        doReset(1'b0);
        expectAt(1, ev(0, 0, 0, 0, 0), "fault_cleared_e1");
        expectAt(4, ev(0, 0, 0, 0, 1), "fault_restart_e4");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (observed !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, observed, e.val);
                end
            end
        end
`endif
    endtask

    task automatic test_relock_run();
        doReset(1'b1);
        expectAt(20, ev(0, 0, 1, 1, 1), "relock_run_e20");
        expectAt(22, ev(0, 0, 1, 1, 1), "relock_still_run_e22");
        expectAt(23, ev(0, 1, 0, 0, 0), "relock_drop_e23");
        expectAt(38, ev(0, 1, 0, 0, 1), "relock_settle_e38");
        expectAt(39, ev(0, 1, 1, 1, 1), "relock_run_e39");
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (observed !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, observed, e.val);
                end
            end
            if (cyc == 20) pll_locked = 1'b0;
            if (cyc == 23) pll_locked = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        vectors++;
        if (observed !== ev(0, 1, 1, 1, 1)) begin
            miscompares++;
            $display("[TB] FAIL async_pre got=%b want=%b", observed, ev(0, 1, 1, 1, 1));
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (observed !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL async_midrun got=%b want=%b", observed, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_relock_saturate();
        int d;
        int rc;
        doReset(1'b1);
        for (int k = 0; k < 17; k++) begin
            d  = 20 + 20 * k;
            rc = (k + 1 > 15) ? 15 : k + 1;
            expectAt(d + 3,  ev(0, 4'(rc), 0, 0, 0), "sat_drop");
            expectAt(d + 19, ev(0, 4'(rc), 1, 1, 1), "sat_run");
        end
        for (int i = 0; i < 362; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (observed !== e.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s cyc=%0d got=%b want=%b", e.name, cyc, observed, e.val);
                end
            end
            if (cyc >= 20 && cyc <= 340 && (cyc - 20) % 20 == 0) pll_locked = 1'b0;
            if (cyc >= 23 && (cyc - 23) % 20 == 0) pll_locked = 1'b1;
        end
        vectors++;
        if (relock_count !== 4'd15) begin
            miscompares++;
            $display("[TB] FAIL sat_final got=%0d want=%0d", relock_count, 15);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        cyc        = 0;
        test_reset();
        test_locked_startup();
        test_lock_glitch();
        test_no_lock();
        test_relock_run();
        test_async_reset();
        test_relock_saturate();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=%0d", sbq.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
